// File: rtl/pipeline_ctrl_sequencer_if.sv
// Handshake and status bundle between the pipeline control sequencer and
// the pipeline datapath / hazard unit / memory ports.
interface pipeline_ctrl_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  // Condition inputs into the sequencer
  logic             hazard_stall_in;
  logic             branch_taken_in;
  logic             dmem_req_in;
  logic             dmem_ready_in;
  logic             imem_ready_in;
  logic             cnt_clear_in;
  // Per-stage controls out of the sequencer
  logic             pc_write_out;
  logic             ifid_write_out;
  logic             ifid_flush_out;
  logic             idex_write_out;
  logic             idex_bubble_out;
  logic             exmem_write_out;
  logic             memwb_bubble_out;
  // Status and performance counters
  logic             mem_timeout_out;
  logic [1:0]       state_out;
  logic [CNT_W-1:0] stall_cnt_out;
  logic [CNT_W-1:0] flush_cnt_out;
  logic [CNT_W-1:0] memwait_cnt_out;

  // Side that raises conditions and consumes the controls
  modport master (
    output hazard_stall_in, branch_taken_in, dmem_req_in, dmem_ready_in, imem_ready_in,
           cnt_clear_in,
    input  pc_write_out, ifid_write_out, ifid_flush_out, idex_write_out, idex_bubble_out,
           exmem_write_out, memwb_bubble_out, mem_timeout_out, state_out, stall_cnt_out,
           flush_cnt_out, memwait_cnt_out
  );

  // The sequencer itself
  modport slave (
    input  hazard_stall_in, branch_taken_in, dmem_req_in, dmem_ready_in, imem_ready_in,
           cnt_clear_in,
    output pc_write_out, ifid_write_out, ifid_flush_out, idex_write_out, idex_bubble_out,
           exmem_write_out, memwb_bubble_out, mem_timeout_out, state_out, stall_cnt_out,
           flush_cnt_out, memwait_cnt_out
  );
endinterface

// File: rtl/pipeline_ctrl_sequencer.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline. Merges hazard
// stall, branch redirect and memory wait conditions into prioritised per-stage
// write-enable / flush / bubble controls, flags data-memory timeouts and keeps
// saturating stall, flush and memory-wait counters.
module pipeline_ctrl_sequencer #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16  // expected >= 2
) (
  input  logic                            clk,
  input  logic                            reset,
  pipeline_ctrl_sequencer_if.slave        bus
);

  localparam int unsigned     WaitW    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StInit    = 2'd0,
    StRun     = 2'd1,
    StMemWait = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble;
  logic freeze, stall_apply, flush_apply;

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v, logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  // Prioritised control decode and next-state selection
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    freeze       = 1'b0;
    stall_apply  = 1'b0;
    state_d      = state_q;
    unique case (state_q)
      StRun, StMemWait: begin
        // Once waiting, only the ready strobe releases the freeze
        freeze = (state_q == StMemWait) ? ~bus.dmem_ready_in
                                        : (bus.dmem_req_in & ~bus.dmem_ready_in);
        if (freeze) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_bubble = 1'b1;
          state_d      = StMemWait;
        end else begin
          state_d = StRun;
          if (bus.hazard_stall_in) begin
            // Branch operands not valid yet, so a taken branch is ignored here
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_apply = 1'b1;
          end else if (bus.branch_taken_in) begin
            // Redirect wins over a missing fetch; that fetch is abandoned
            ifid_flush = 1'b1;
          end else if (!bus.imem_ready_in) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
          end
        end
      end
      default: begin
        // Post-reset hold cycle (also absorbs the unused encoding)
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b1;
        idex_write   = 1'b0;
        idex_bubble  = 1'b1;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
        state_d      = StRun;
      end
    endcase
  end

  assign flush_apply = ifid_flush & (state_q != StInit);

  // Consecutive MEM_WAIT cycle counter and sticky timeout flag
  always_comb begin
    wait_d    = '0;
    timeout_d = timeout_q;
    if ((state_q == StMemWait) && !bus.dmem_ready_in) begin
      wait_d = (wait_q == WaitLast) ? wait_q : wait_q + 1'b1;
      if (wait_d == WaitLast) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Saturating performance counters; clear beats increment
  always_comb begin
    stall_cnt_d   = sat_inc(stall_cnt_q, stall_apply);
    flush_cnt_d   = sat_inc(flush_cnt_q, flush_apply);
    memwait_cnt_d = sat_inc(memwait_cnt_q, freeze);
    if (bus.cnt_clear_in) begin
      stall_cnt_d   = '0;
      flush_cnt_d   = '0;
      memwait_cnt_d = '0;
    end
  end

  // State, wait counter, error flag and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StInit;
      wait_q        <= '0;
      timeout_q     <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      timeout_q     <= timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign bus.pc_write_out     = pc_write;
  assign bus.ifid_write_out   = ifid_write;
  assign bus.ifid_flush_out   = ifid_flush;
  assign bus.idex_write_out   = idex_write;
  assign bus.idex_bubble_out  = idex_bubble;
  assign bus.exmem_write_out  = exmem_write;
  assign bus.memwb_bubble_out = memwb_bubble;
  assign bus.mem_timeout_out  = timeout_q;
  assign bus.state_out        = state_q;
  assign bus.stall_cnt_out    = stall_cnt_q;
  assign bus.flush_cnt_out    = flush_cnt_q;
  assign bus.memwait_cnt_out  = memwait_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl_sequencer.sv
// Bench for pipeline_ctrl_sequencer: directed scenarios with literal
// expectations, then randomized traffic, all compared against a behavioural
// model (control truth table, freeze-run length, saturating counts).
module tb_pipeline_ctrl_sequencer;

  localparam int unsigned CW  = 4;
  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_ctrl_sequencer_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl_sequencer #(.CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state: in hold cycle, previous cycle was frozen, freeze run length
  bit          m_init;
  bit          m_wait;
  int          m_run;
  bit          m_tmo;
  logic [CW-1:0] m_stall, m_flush, m_mw;

  // {pc_w, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, memwb_bubble}
  function automatic logic [6:0] exp_ctrl(bit init, bit waiting, logic hz, logic br,
                                          logic req, logic rdy, logic imem);
    if (init)                                   return 7'b0010101;
    if (waiting ? !rdy : (req && !rdy))         return 7'b0000001;
    if (hz)                                     return 7'b0001110;
    if (br)                                     return 7'b1111010;
    if (!imem)                                  return 7'b0111010;
    return 7'b1101010;
  endfunction

  function automatic logic [6:0] act_ctrl();
    return {bus.pc_write_out, bus.ifid_write_out, bus.ifid_flush_out, bus.idex_write_out,
            bus.idex_bubble_out, bus.exmem_write_out, bus.memwb_bubble_out};
  endfunction

  // Model update on the same edges as the design
  always @(posedge clk or posedge reset) begin
    logic [6:0] e;
    bit frz, stl, fls;
    int run;
    if (reset) begin
      m_init  <= 1'b1;
      m_wait  <= 1'b0;
      m_run   <= 0;
      m_tmo   <= 1'b0;
      m_stall <= '0;
      m_flush <= '0;
      m_mw    <= '0;
    end else begin
      e   = exp_ctrl(m_init, m_wait, bus.hazard_stall_in, bus.branch_taken_in,
                     bus.dmem_req_in, bus.dmem_ready_in, bus.imem_ready_in);
      frz = !m_init && (m_wait ? !bus.dmem_ready_in
                               : (bus.dmem_req_in && !bus.dmem_ready_in));
      stl = !m_init && !frz && bus.hazard_stall_in;
      fls = !m_init && e[4];
      run = frz ? m_run + 1 : 0;
      m_run  <= run;
      // A freeze run of TMO cycles is TMO-1 cycles spent in MEM_WAIT
      if (run >= int'(TMO)) m_tmo <= 1'b1;
      m_wait <= frz;
      m_init <= 1'b0;
      if (bus.cnt_clear_in) begin
        m_stall <= '0;
        m_flush <= '0;
        m_mw    <= '0;
      end else begin
        if (stl && m_stall != '1) m_stall <= m_stall + 1'b1;
        if (fls && m_flush != '1) m_flush <= m_flush + 1'b1;
        if (frz && m_mw != '1)    m_mw    <= m_mw + 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("ctrl", 32'(act_ctrl()),
        32'(exp_ctrl(m_init, m_wait, bus.hazard_stall_in, bus.branch_taken_in,
                     bus.dmem_req_in, bus.dmem_ready_in, bus.imem_ready_in)));
    chk("state", 32'(bus.state_out), m_init ? 32'd0 : (m_wait ? 32'd2 : 32'd1));
    chk("timeout", 32'(bus.mem_timeout_out), 32'(m_tmo));
    chk("stall_cnt", 32'(bus.stall_cnt_out), 32'(m_stall));
    chk("flush_cnt", 32'(bus.flush_cnt_out), 32'(m_flush));
    chk("memwait_cnt", 32'(bus.memwait_cnt_out), 32'(m_mw));
  endtask

  // One cycle: apply inputs after the edge, check before the next edge
  task automatic drive(input bit rst, input bit hz, input bit br, input bit req,
                       input bit rdy, input bit imem, input bit clr);
    @(posedge clk);
    #1;
    reset               = rst;
    bus.hazard_stall_in = hz;
    bus.branch_taken_in = br;
    bus.dmem_req_in     = req;
    bus.dmem_ready_in   = rdy;
    bus.imem_ready_in   = imem;
    bus.cnt_clear_in    = clr;
    #3;
    check_all();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 1, 1, 0);
  endtask

  initial begin
    reset               = 1'b1;
    bus.hazard_stall_in = 1'b0;
    bus.branch_taken_in = 1'b0;
    bus.dmem_req_in     = 1'b0;
    bus.dmem_ready_in   = 1'b1;
    bus.imem_ready_in   = 1'b1;
    bus.cnt_clear_in    = 1'b0;

    // Reset and hold cycle
    drive(1, 0, 0, 0, 1, 1, 0);
    chk("rst_state", 32'(bus.state_out), 32'd0);
    chk("rst_ctrl", 32'(act_ctrl()), 32'h15);
    idle();
    chk("init_state", 32'(bus.state_out), 32'd0);
    chk("init_ctrl", 32'(act_ctrl()), 32'h15);
    idle();
    chk("run_state", 32'(bus.state_out), 32'd1);
    chk("run_ctrl", 32'(act_ctrl()), 32'h6A);
    chk("run_cnt0", 32'(bus.stall_cnt_out), 32'd0);

    // Hazard stall masks a simultaneous taken branch
    drive(0, 1, 1, 0, 1, 1, 0);
    chk("hz_br_ctrl", 32'(act_ctrl()), 32'h0E);
    idle();
    chk("hz_stall_cnt", 32'(bus.stall_cnt_out), 32'd1);
    chk("hz_flush_cnt", 32'(bus.flush_cnt_out), 32'd0);

    // Three frozen cycles then ready
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 0, 1, 0, 1, 0);
      chk("frz_ctrl", 32'(act_ctrl()), 32'h01);
      if (i > 1) chk("frz_state", 32'(bus.state_out), 32'd2);
    end
    drive(0, 0, 0, 1, 1, 1, 0);
    chk("rdy_ctrl", 32'(act_ctrl()), 32'h6A);
    idle();
    chk("rdy_state", 32'(bus.state_out), 32'd1);
    chk("memwait3", 32'(bus.memwait_cnt_out), 32'd3);

    // Fetch miss, then branch during fetch miss
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("imiss_ctrl", 32'(act_ctrl()), 32'h3A);
    drive(0, 0, 1, 0, 1, 0, 0);
    chk("imiss_br_ctrl", 32'(act_ctrl()), 32'h7A);
    idle();
    chk("flush2", 32'(bus.flush_cnt_out), 32'd2);

    // Data-memory timeout is sticky until reset
    for (int i = 1; i <= 6; i++) begin
      drive(0, 0, 0, 1, 0, 1, 0);
      if (i == 3) chk("tmo_early", 32'(bus.mem_timeout_out), 32'd0);
      if (i == 6) chk("tmo_set", 32'(bus.mem_timeout_out), 32'd1);
    end
    drive(0, 0, 0, 1, 1, 1, 0);
    idle();
    chk("tmo_sticky", 32'(bus.mem_timeout_out), 32'd1);

    // Counter saturation and clear priority
    drive(0, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 1, 1, 0);
    idle();
    chk("stall_sat", 32'(bus.stall_cnt_out), 32'd15);
    drive(0, 1, 0, 0, 1, 1, 1);
    idle();
    chk("clr_prio", 32'(bus.stall_cnt_out), 32'd0);

    // Reset during a memory wait abandons it and clears the error
    drive(0, 0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 1, 0);
    drive(1, 0, 0, 1, 0, 1, 0);
    chk("rst_wait_state", 32'(bus.state_out), 32'd0);
    chk("rst_tmo", 32'(bus.mem_timeout_out), 32'd0);
    idle();
    idle();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 29) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
